axi4_arb2: RTL and testbench
============================

Name: axi4_arb2

Overview:
- Two-requester AXI4 arbiter that shares the CPU TCM target port (axi_t) between the USB bridge master and a second bus master, such as a debug/loader bridge.
- Read and write paths are arbitrated independently.
- Each path carries one transaction in flight.
- The response channel routes back to the granted requester from a registered grant, so IDs pass through unmodified.

Parameters:
ROUND_ROBIN, 1, 1 = round-robin between requesters; 0 = fixed priority, inport0 always wins.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
inportN_awvalid_i/awaddr_i/awid_i/awlen_i/awburst_i  in  1/32/4/8/2  write address, requester N (N=0,1)
inportN_wvalid_i/wdata_i/wstrb_i/wlast_i  in  1/32/4/1  write data, requester N
inportN_bready_i  in  1  write response ready, requester N
inportN_arvalid_i/araddr_i/arid_i/arlen_i/arburst_i  in  1/32/4/8/2  read address, requester N
inportN_rready_i  in  1  read data ready, requester N
inportN_awready_o/wready_o/arready_o  out  1 each  channel readies to requester N
inportN_bvalid_o/bresp_o/bid_o  out  1/2/4  write response to requester N
inportN_rvalid_o/rdata_o/rresp_o/rid_o/rlast_o  out  1/32/2/4/1  read data to requester N
outport_awvalid_o/awaddr_o/awid_o/awlen_o/awburst_o  out  1/32/4/8/2  write address to target
outport_wvalid_o/wdata_o/wstrb_o/wlast_o/bready_o  out  1/32/4/1/1  write data, response ready to target
outport_arvalid_o/araddr_o/arid_o/arlen_o/arburst_o/rready_o  out  1/32/4/8/2/1  read address, read ready to target
outport_awready_i/wready_i/arready_i  in  1 each  target readies
outport_bvalid_i/bresp_i/bid_i  in  1/2/4  target write response
outport_rvalid_i/rdata_i/rresp_i/rid_i/rlast_i  in  1/32/2/4/1  target read data

Behaviour:
- Write FSM, states WR_IDLE, WR_ADDR, WR_DATA, WR_RESP:
  - WR_IDLE: on any inportN_awvalid_i, latch wr_grant and go to WR_ADDR. This adds 1 cycle of arbitration latency.
  - WR_ADDR: outport_aw* = granted inport aw*; granted awready_o = outport_awready_i. On AW handshake go to WR_DATA.
  - WR_DATA: W channel muxed from the granted port, ready routed back. On a W handshake with wlast=1 go to WR_RESP.
  - WR_RESP: outport_bready_o = granted bready; granted bvalid/bresp/bid driven from the outport. On B handshake go to WR_IDLE.
- Read FSM, states RD_IDLE, RD_ADDR, RD_DATA, independent of the write FSM:
  - Same pattern: arbitrate in RD_IDLE, forward AR in RD_ADDR, forward R beats in RD_DATA.
  - Return to RD_IDLE on an R handshake with rlast=1.
- Arbitration:
  - A single requester wins immediately.
  - Both requesting with ROUND_ROBIN=1: the winner is the port not granted last on that path. The last-grant register updates on each grant and resets to 1, so inport0 wins the first contention.
  - With ROUND_ROBIN=0, inport0 always wins.
- Non-granted and idle ports: all *ready_o/*valid_o = 0. Payload outputs are don't-care but driven from the granted mux, with no X.
- Outport valids are 0 in IDLE and in any state whose channel is not active.
  - Example: outport_wvalid_o=0 outside WR_DATA.
  - W beats presented before AW is accepted are stalled (wready_o=0).
- Requesters hold valid and payload until ready, per AXI4; the block does not check this. A losing requester's request stays pending and is granted after the current transaction.
- Response routing uses the registered grant only. bid/rid pass through unmodified and are not decoded.
- Burst length is bounded only by wlast/rlast; awlen/arlen are passed through and not counted.
- Simultaneous read and write on the same or different ports proceed concurrently.
- Reset values: assertion of rst_i at any time forces both FSMs to IDLE and all valid/ready outputs to 0 asynchronously, and sets last-grant to 1. An in-flight burst is abandoned; the target and requesters are reset by the same rst_i.
- Throughput: one write plus one read transaction concurrently. Minimum gap between transactions on a path is 1 idle cycle.

Test Plan:
- Single write: inport0 writes awaddr=0x100, awlen=3, 4 beats 0xA0..A3 -> outport sees identical AW/W, wlast on beat 4; bid=0x2 returned only on inport0; inport1 readies stay 0.
- Contention: both awvalid in the same cycle after reset -> inport0 granted first, inport1 next. Repeat -> inport1 first (round-robin alternation). With ROUND_ROBIN=0 -> inport0 always first.
- Concurrent R/W: inport0 reads 8 beats (arlen=7) while inport1 writes 1 beat -> both complete; rdata order preserved; rlast only on beat 8.
- Backpressure: outport_wready_i toggles every cycle, rready_i low for 5 cycles mid-burst -> no beat lost or duplicated; data matches in order.
- Early W: inport1 asserts wvalid 3 cycles before awvalid -> wready_o held 0 until the AW handshake completes.
- Reset mid-burst: assert rst_i during beat 2 of 4 -> all valid/ready outputs 0 in the same cycle. After release, a new inport1 write completes normally.

Source files
------------

// File: rtl/axi4_arb2.sv
// -----------------------------------------------------------------------------
// axi4_arb2
// Two-requester AXI4 arbiter. It shares one target port (the CPU TCM port)
// between two masters, for example the USB bridge and a debug/loader bridge.
// The read and write paths are arbitrated independently. Each path carries one
// transaction at a time. Responses are steered back using the registered grant,
// so the IDs pass through unmodified.
//
// Parameters:
//   ROUND_ROBIN  1 = alternate between requesters under contention,
//                0 = fixed priority, inport0 always wins
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   inportN_aw*/w*/b*       write channels of requester N (N = 0, 1)
//   inportN_ar*/r*          read channels of requester N
//   outport_aw*/w*/b*       write channels toward the shared target
//   outport_ar*/r*          read channels toward the shared target
// -----------------------------------------------------------------------------
module axi4_arb2 #(
    parameter logic ROUND_ROBIN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // requester 0
    input  logic        inport0_awvalid_i,
    input  logic [31:0] inport0_awaddr_i,
    input  logic [3:0]  inport0_awid_i,
    input  logic [7:0]  inport0_awlen_i,
    input  logic [1:0]  inport0_awburst_i,
    input  logic        inport0_wvalid_i,
    input  logic [31:0] inport0_wdata_i,
    input  logic [3:0]  inport0_wstrb_i,
    input  logic        inport0_wlast_i,
    input  logic        inport0_bready_i,
    input  logic        inport0_arvalid_i,
    input  logic [31:0] inport0_araddr_i,
    input  logic [3:0]  inport0_arid_i,
    input  logic [7:0]  inport0_arlen_i,
    input  logic [1:0]  inport0_arburst_i,
    input  logic        inport0_rready_i,
    output logic        inport0_awready_o,
    output logic        inport0_wready_o,
    output logic        inport0_arready_o,
    output logic        inport0_bvalid_o,
    output logic [1:0]  inport0_bresp_o,
    output logic [3:0]  inport0_bid_o,
    output logic        inport0_rvalid_o,
    output logic [31:0] inport0_rdata_o,
    output logic [1:0]  inport0_rresp_o,
    output logic [3:0]  inport0_rid_o,
    output logic        inport0_rlast_o,
    // requester 1
    input  logic        inport1_awvalid_i,
    input  logic [31:0] inport1_awaddr_i,
    input  logic [3:0]  inport1_awid_i,
    input  logic [7:0]  inport1_awlen_i,
    input  logic [1:0]  inport1_awburst_i,
    input  logic        inport1_wvalid_i,
    input  logic [31:0] inport1_wdata_i,
    input  logic [3:0]  inport1_wstrb_i,
    input  logic        inport1_wlast_i,
    input  logic        inport1_bready_i,
    input  logic        inport1_arvalid_i,
    input  logic [31:0] inport1_araddr_i,
    input  logic [3:0]  inport1_arid_i,
    input  logic [7:0]  inport1_arlen_i,
    input  logic [1:0]  inport1_arburst_i,
    input  logic        inport1_rready_i,
    output logic        inport1_awready_o,
    output logic        inport1_wready_o,
    output logic        inport1_arready_o,
    output logic        inport1_bvalid_o,
    output logic [1:0]  inport1_bresp_o,
    output logic [3:0]  inport1_bid_o,
    output logic        inport1_rvalid_o,
    output logic [31:0] inport1_rdata_o,
    output logic [1:0]  inport1_rresp_o,
    output logic [3:0]  inport1_rid_o,
    output logic        inport1_rlast_o,
    // shared target
    output logic        outport_awvalid_o,
    output logic [31:0] outport_awaddr_o,
    output logic [3:0]  outport_awid_o,
    output logic [7:0]  outport_awlen_o,
    output logic [1:0]  outport_awburst_o,
    output logic        outport_wvalid_o,
    output logic [31:0] outport_wdata_o,
    output logic [3:0]  outport_wstrb_o,
    output logic        outport_wlast_o,
    output logic        outport_bready_o,
    output logic        outport_arvalid_o,
    output logic [31:0] outport_araddr_o,
    output logic [3:0]  outport_arid_o,
    output logic [7:0]  outport_arlen_o,
    output logic [1:0]  outport_arburst_o,
    output logic        outport_rready_o,
    input  logic        outport_awready_i,
    input  logic        outport_wready_i,
    input  logic        outport_arready_i,
    input  logic        outport_bvalid_i,
    input  logic [1:0]  outport_bresp_i,
    input  logic [3:0]  outport_bid_i,
    input  logic        outport_rvalid_i,
    input  logic [31:0] outport_rdata_i,
    input  logic [1:0]  outport_rresp_i,
    input  logic [3:0]  outport_rid_i,
    input  logic        outport_rlast_i
);

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_DATA = 2'd2,
        WR_RESP = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_t;

    // Pick the winning requester (0 or 1) from the two requests and the port
    // granted last on this path.
    function automatic logic arb_pick(input logic req0, input logic req1,
                                      input logic last_grant);
        logic win;
        if (req0 && req1) begin
            if (ROUND_ROBIN) begin
                win = ~last_grant;
            end else begin
                win = 1'b0;
            end
        end else if (req1) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
        return win;
    endfunction

    wr_state_t wr_state_r, wr_next_s;
    rd_state_t rd_state_r, rd_next_s;

    // The grant register also serves as the last-grant register. Its reset
    // value of 1 makes inport0 win the first contention.
    logic wr_grant_r;
    logic rd_grant_r;

    logic wr_req_s, rd_req_s, wr_win_s, rd_win_s;
    logic wr_sel_awvalid_s, wr_sel_wvalid_s, wr_sel_bready_s;
    logic rd_sel_arvalid_s, rd_sel_rready_s;

    assign wr_req_s = inport0_awvalid_i | inport1_awvalid_i;
    assign rd_req_s = inport0_arvalid_i | inport1_arvalid_i;
    assign wr_win_s = arb_pick(inport0_awvalid_i, inport1_awvalid_i, wr_grant_r);
    assign rd_win_s = arb_pick(inport0_arvalid_i, inport1_arvalid_i, rd_grant_r);

    assign wr_sel_awvalid_s = wr_grant_r ? inport1_awvalid_i : inport0_awvalid_i;
    assign wr_sel_wvalid_s  = wr_grant_r ? inport1_wvalid_i  : inport0_wvalid_i;
    assign wr_sel_bready_s  = wr_grant_r ? inport1_bready_i  : inport0_bready_i;
    assign rd_sel_arvalid_s = rd_grant_r ? inport1_arvalid_i : inport0_arvalid_i;
    assign rd_sel_rready_s  = rd_grant_r ? inport1_rready_i  : inport0_rready_i;

    // Payloads always follow the grant mux, so they are never X. Only the
    // valid/ready qualifiers are gated by state.
    assign outport_awaddr_o  = wr_grant_r ? inport1_awaddr_i  : inport0_awaddr_i;
    assign outport_awid_o    = wr_grant_r ? inport1_awid_i    : inport0_awid_i;
    assign outport_awlen_o   = wr_grant_r ? inport1_awlen_i   : inport0_awlen_i;
    assign outport_awburst_o = wr_grant_r ? inport1_awburst_i : inport0_awburst_i;
    assign outport_wdata_o   = wr_grant_r ? inport1_wdata_i   : inport0_wdata_i;
    assign outport_wstrb_o   = wr_grant_r ? inport1_wstrb_i   : inport0_wstrb_i;
    assign outport_wlast_o   = wr_grant_r ? inport1_wlast_i   : inport0_wlast_i;
    assign outport_araddr_o  = rd_grant_r ? inport1_araddr_i  : inport0_araddr_i;
    assign outport_arid_o    = rd_grant_r ? inport1_arid_i    : inport0_arid_i;
    assign outport_arlen_o   = rd_grant_r ? inport1_arlen_i   : inport0_arlen_i;
    assign outport_arburst_o = rd_grant_r ? inport1_arburst_i : inport0_arburst_i;

    assign inport0_bresp_o = outport_bresp_i;
    assign inport0_bid_o   = outport_bid_i;
    assign inport1_bresp_o = outport_bresp_i;
    assign inport1_bid_o   = outport_bid_i;
    assign inport0_rdata_o = outport_rdata_i;
    assign inport0_rresp_o = outport_rresp_i;
    assign inport0_rid_o   = outport_rid_i;
    assign inport0_rlast_o = outport_rlast_i;
    assign inport1_rdata_o = outport_rdata_i;
    assign inport1_rresp_o = outport_rresp_i;
    assign inport1_rid_o   = outport_rid_i;
    assign inport1_rlast_o = outport_rlast_i;

    // Write path state and grant registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state_r <= WR_IDLE;
            wr_grant_r <= 1'b1;
        end else begin
            wr_state_r <= wr_next_s;
            if ((wr_state_r == WR_IDLE) && wr_req_s) begin
                wr_grant_r <= wr_win_s;
            end
        end
    end

    // Read path state and grant registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state_r <= RD_IDLE;
            rd_grant_r <= 1'b1;
        end else begin
            rd_state_r <= rd_next_s;
            if ((rd_state_r == RD_IDLE) && rd_req_s) begin
                rd_grant_r <= rd_win_s;
            end
        end
    end

    // Write path next state and channel qualifiers.
    always_comb begin
        wr_next_s         = wr_state_r;
        outport_awvalid_o = 1'b0;
        outport_wvalid_o  = 1'b0;
        outport_bready_o  = 1'b0;
        inport0_awready_o = 1'b0;
        inport1_awready_o = 1'b0;
        inport0_wready_o  = 1'b0;
        inport1_wready_o  = 1'b0;
        inport0_bvalid_o  = 1'b0;
        inport1_bvalid_o  = 1'b0;
        case (wr_state_r)
            WR_IDLE: begin
                if (wr_req_s) begin
                    wr_next_s = WR_ADDR;
                end else begin
                    wr_next_s = WR_IDLE;
                end
            end
            WR_ADDR: begin
                outport_awvalid_o = wr_sel_awvalid_s;
                if (wr_grant_r) begin
                    inport1_awready_o = outport_awready_i;
                end else begin
                    inport0_awready_o = outport_awready_i;
                end
                if (wr_sel_awvalid_s && outport_awready_i) begin
                    wr_next_s = WR_DATA;
                end else begin
                    wr_next_s = WR_ADDR;
                end
            end
            WR_DATA: begin
                outport_wvalid_o = wr_sel_wvalid_s;
                if (wr_grant_r) begin
                    inport1_wready_o = outport_wready_i;
                end else begin
                    inport0_wready_o = outport_wready_i;
                end
                if (wr_sel_wvalid_s && outport_wready_i && outport_wlast_o) begin
                    wr_next_s = WR_RESP;
                end else begin
                    wr_next_s = WR_DATA;
                end
            end
            WR_RESP: begin
                outport_bready_o = wr_sel_bready_s;
                if (wr_grant_r) begin
                    inport1_bvalid_o = outport_bvalid_i;
                end else begin
                    inport0_bvalid_o = outport_bvalid_i;
                end
                if (outport_bvalid_i && wr_sel_bready_s) begin
                    wr_next_s = WR_IDLE;
                end else begin
                    wr_next_s = WR_RESP;
                end
            end
            default: begin
                wr_next_s = WR_IDLE;
            end
        endcase
    end

    // Read path next state and channel qualifiers.
    always_comb begin
        rd_next_s         = rd_state_r;
        outport_arvalid_o = 1'b0;
        outport_rready_o  = 1'b0;
        inport0_arready_o = 1'b0;
        inport1_arready_o = 1'b0;
        inport0_rvalid_o  = 1'b0;
        inport1_rvalid_o  = 1'b0;
        case (rd_state_r)
            RD_IDLE: begin
                if (rd_req_s) begin
                    rd_next_s = RD_ADDR;
                end else begin
                    rd_next_s = RD_IDLE;
                end
            end
            RD_ADDR: begin
                outport_arvalid_o = rd_sel_arvalid_s;
                if (rd_grant_r) begin
                    inport1_arready_o = outport_arready_i;
                end else begin
                    inport0_arready_o = outport_arready_i;
                end
                if (rd_sel_arvalid_s && outport_arready_i) begin
                    rd_next_s = RD_DATA;
                end else begin
                    rd_next_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                outport_rready_o = rd_sel_rready_s;
                if (rd_grant_r) begin
                    inport1_rvalid_o = outport_rvalid_i;
                end else begin
                    inport0_rvalid_o = outport_rvalid_i;
                end
                if (outport_rvalid_i && rd_sel_rready_s && outport_rlast_i) begin
                    rd_next_s = RD_IDLE;
                end else begin
                    rd_next_s = RD_DATA;
                end
            end
            default: begin
                rd_next_s = RD_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi4_arb2.sv
// -----------------------------------------------------------------------------
// tb_axi4_arb2
// Directed testbench for axi4_arb2. The main instance uses round-robin
// arbitration. A second instance with fixed priority receives the same
// stimulus and is checked only during contention.
// -----------------------------------------------------------------------------
module tb_axi4_arb2;

    logic clk, rst;
    int   tests = 0;
    int   fails = 0;

    // requester-side and target-side stimulus
    logic        inport0_awvalid_i, inport1_awvalid_i;
    logic [31:0] inport0_awaddr_i, inport1_awaddr_i;
    logic [3:0]  inport0_awid_i, inport1_awid_i;
    logic [7:0]  inport0_awlen_i, inport1_awlen_i;
    logic [1:0]  inport0_awburst_i, inport1_awburst_i;
    logic        inport0_wvalid_i, inport1_wvalid_i;
    logic [31:0] inport0_wdata_i, inport1_wdata_i;
    logic [3:0]  inport0_wstrb_i, inport1_wstrb_i;
    logic        inport0_wlast_i, inport1_wlast_i;
    logic        inport0_bready_i, inport1_bready_i;
    logic        inport0_arvalid_i, inport1_arvalid_i;
    logic [31:0] inport0_araddr_i, inport1_araddr_i;
    logic [3:0]  inport0_arid_i, inport1_arid_i;
    logic [7:0]  inport0_arlen_i, inport1_arlen_i;
    logic [1:0]  inport0_arburst_i, inport1_arburst_i;
    logic        inport0_rready_i, inport1_rready_i;
    logic        outport_awready_i, outport_wready_i, outport_arready_i;
    logic        outport_bvalid_i;
    logic [1:0]  outport_bresp_i;
    logic [3:0]  outport_bid_i;
    logic        outport_rvalid_i;
    logic [31:0] outport_rdata_i;
    logic [1:0]  outport_rresp_i;
    logic [3:0]  outport_rid_i;
    logic        outport_rlast_i;

    // main DUT outputs
    logic        inport0_awready_o, inport0_wready_o, inport0_arready_o, inport0_bvalid_o;
    logic [1:0]  inport0_bresp_o;
    logic [3:0]  inport0_bid_o;
    logic        inport0_rvalid_o, inport0_rlast_o;
    logic [31:0] inport0_rdata_o;
    logic [1:0]  inport0_rresp_o;
    logic [3:0]  inport0_rid_o;
    logic        inport1_awready_o, inport1_wready_o, inport1_arready_o, inport1_bvalid_o;
    logic [1:0]  inport1_bresp_o;
    logic [3:0]  inport1_bid_o;
    logic        inport1_rvalid_o, inport1_rlast_o;
    logic [31:0] inport1_rdata_o;
    logic [1:0]  inport1_rresp_o;
    logic [3:0]  inport1_rid_o;
    logic        outport_awvalid_o, outport_wvalid_o, outport_wlast_o, outport_bready_o;
    logic [31:0] outport_awaddr_o, outport_wdata_o, outport_araddr_o;
    logic [3:0]  outport_awid_o, outport_wstrb_o, outport_arid_o;
    logic [7:0]  outport_awlen_o, outport_arlen_o;
    logic [1:0]  outport_awburst_o, outport_arburst_o;
    logic        outport_arvalid_o, outport_rready_o;

    // fixed-priority DUT outputs
    logic        r0_inport0_awready_o, r0_inport0_wready_o, r0_inport0_arready_o, r0_inport0_bvalid_o;
    logic [1:0]  r0_inport0_bresp_o;
    logic [3:0]  r0_inport0_bid_o;
    logic        r0_inport0_rvalid_o, r0_inport0_rlast_o;
    logic [31:0] r0_inport0_rdata_o;
    logic [1:0]  r0_inport0_rresp_o;
    logic [3:0]  r0_inport0_rid_o;
    logic        r0_inport1_awready_o, r0_inport1_wready_o, r0_inport1_arready_o, r0_inport1_bvalid_o;
    logic [1:0]  r0_inport1_bresp_o;
    logic [3:0]  r0_inport1_bid_o;
    logic        r0_inport1_rvalid_o, r0_inport1_rlast_o;
    logic [31:0] r0_inport1_rdata_o;
    logic [1:0]  r0_inport1_rresp_o;
    logic [3:0]  r0_inport1_rid_o;
    logic        r0_outport_awvalid_o, r0_outport_wvalid_o, r0_outport_wlast_o, r0_outport_bready_o;
    logic [31:0] r0_outport_awaddr_o, r0_outport_wdata_o, r0_outport_araddr_o;
    logic [3:0]  r0_outport_awid_o, r0_outport_wstrb_o, r0_outport_arid_o;
    logic [7:0]  r0_outport_awlen_o, r0_outport_arlen_o;
    logic [1:0]  r0_outport_awburst_o, r0_outport_arburst_o;
    logic        r0_outport_arvalid_o, r0_outport_rready_o;

    // every valid/ready output of the main DUT, which must all be 0 in reset
    logic [14:0] vr_all;
    assign vr_all = {outport_awvalid_o, outport_wvalid_o, outport_bready_o,
                     outport_arvalid_o, outport_rready_o,
                     inport0_awready_o, inport0_wready_o, inport0_arready_o,
                     inport0_bvalid_o, inport0_rvalid_o,
                     inport1_awready_o, inport1_wready_o, inport1_arready_o,
                     inport1_bvalid_o, inport1_rvalid_o};

    axi4_arb2 #(.ROUND_ROBIN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .inport0_awvalid_i(inport0_awvalid_i), .inport0_awaddr_i(inport0_awaddr_i),
        .inport0_awid_i(inport0_awid_i), .inport0_awlen_i(inport0_awlen_i),
        .inport0_awburst_i(inport0_awburst_i), .inport0_wvalid_i(inport0_wvalid_i),
        .inport0_wdata_i(inport0_wdata_i), .inport0_wstrb_i(inport0_wstrb_i),
        .inport0_wlast_i(inport0_wlast_i), .inport0_bready_i(inport0_bready_i),
        .inport0_arvalid_i(inport0_arvalid_i), .inport0_araddr_i(inport0_araddr_i),
        .inport0_arid_i(inport0_arid_i), .inport0_arlen_i(inport0_arlen_i),
        .inport0_arburst_i(inport0_arburst_i), .inport0_rready_i(inport0_rready_i),
        .inport0_awready_o(inport0_awready_o), .inport0_wready_o(inport0_wready_o),
        .inport0_arready_o(inport0_arready_o), .inport0_bvalid_o(inport0_bvalid_o),
        .inport0_bresp_o(inport0_bresp_o), .inport0_bid_o(inport0_bid_o),
        .inport0_rvalid_o(inport0_rvalid_o), .inport0_rdata_o(inport0_rdata_o),
        .inport0_rresp_o(inport0_rresp_o), .inport0_rid_o(inport0_rid_o),
        .inport0_rlast_o(inport0_rlast_o),
        .inport1_awvalid_i(inport1_awvalid_i), .inport1_awaddr_i(inport1_awaddr_i),
        .inport1_awid_i(inport1_awid_i), .inport1_awlen_i(inport1_awlen_i),
        .inport1_awburst_i(inport1_awburst_i), .inport1_wvalid_i(inport1_wvalid_i),
        .inport1_wdata_i(inport1_wdata_i), .inport1_wstrb_i(inport1_wstrb_i),
        .inport1_wlast_i(inport1_wlast_i), .inport1_bready_i(inport1_bready_i),
        .inport1_arvalid_i(inport1_arvalid_i), .inport1_araddr_i(inport1_araddr_i),
        .inport1_arid_i(inport1_arid_i), .inport1_arlen_i(inport1_arlen_i),
        .inport1_arburst_i(inport1_arburst_i), .inport1_rready_i(inport1_rready_i),
        .inport1_awready_o(inport1_awready_o), .inport1_wready_o(inport1_wready_o),
        .inport1_arready_o(inport1_arready_o), .inport1_bvalid_o(inport1_bvalid_o),
        .inport1_bresp_o(inport1_bresp_o), .inport1_bid_o(inport1_bid_o),
        .inport1_rvalid_o(inport1_rvalid_o), .inport1_rdata_o(inport1_rdata_o),
        .inport1_rresp_o(inport1_rresp_o), .inport1_rid_o(inport1_rid_o),
        .inport1_rlast_o(inport1_rlast_o),
        .outport_awvalid_o(outport_awvalid_o), .outport_awaddr_o(outport_awaddr_o),
        .outport_awid_o(outport_awid_o), .outport_awlen_o(outport_awlen_o),
        .outport_awburst_o(outport_awburst_o), .outport_wvalid_o(outport_wvalid_o),
        .outport_wdata_o(outport_wdata_o), .outport_wstrb_o(outport_wstrb_o),
        .outport_wlast_o(outport_wlast_o), .outport_bready_o(outport_bready_o),
        .outport_arvalid_o(outport_arvalid_o), .outport_araddr_o(outport_araddr_o),
        .outport_arid_o(outport_arid_o), .outport_arlen_o(outport_arlen_o),
        .outport_arburst_o(outport_arburst_o), .outport_rready_o(outport_rready_o),
        .outport_awready_i(outport_awready_i), .outport_wready_i(outport_wready_i),
        .outport_arready_i(outport_arready_i), .outport_bvalid_i(outport_bvalid_i),
        .outport_bresp_i(outport_bresp_i), .outport_bid_i(outport_bid_i),
        .outport_rvalid_i(outport_rvalid_i), .outport_rdata_i(outport_rdata_i),
        .outport_rresp_i(outport_rresp_i), .outport_rid_i(outport_rid_i),
        .outport_rlast_i(outport_rlast_i)
    );

    axi4_arb2 #(.ROUND_ROBIN(1'b0)) dut_fixed (
        .clk_i(clk), .rst_i(rst),
        .inport0_awvalid_i(inport0_awvalid_i), .inport0_awaddr_i(inport0_awaddr_i),
        .inport0_awid_i(inport0_awid_i), .inport0_awlen_i(inport0_awlen_i),
        .inport0_awburst_i(inport0_awburst_i), .inport0_wvalid_i(inport0_wvalid_i),
        .inport0_wdata_i(inport0_wdata_i), .inport0_wstrb_i(inport0_wstrb_i),
        .inport0_wlast_i(inport0_wlast_i), .inport0_bready_i(inport0_bready_i),
        .inport0_arvalid_i(inport0_arvalid_i), .inport0_araddr_i(inport0_araddr_i),
        .inport0_arid_i(inport0_arid_i), .inport0_arlen_i(inport0_arlen_i),
        .inport0_arburst_i(inport0_arburst_i), .inport0_rready_i(inport0_rready_i),
        .inport0_awready_o(r0_inport0_awready_o), .inport0_wready_o(r0_inport0_wready_o),
        .inport0_arready_o(r0_inport0_arready_o), .inport0_bvalid_o(r0_inport0_bvalid_o),
        .inport0_bresp_o(r0_inport0_bresp_o), .inport0_bid_o(r0_inport0_bid_o),
        .inport0_rvalid_o(r0_inport0_rvalid_o), .inport0_rdata_o(r0_inport0_rdata_o),
        .inport0_rresp_o(r0_inport0_rresp_o), .inport0_rid_o(r0_inport0_rid_o),
        .inport0_rlast_o(r0_inport0_rlast_o),
        .inport1_awvalid_i(inport1_awvalid_i), .inport1_awaddr_i(inport1_awaddr_i),
        .inport1_awid_i(inport1_awid_i), .inport1_awlen_i(inport1_awlen_i),
        .inport1_awburst_i(inport1_awburst_i), .inport1_wvalid_i(inport1_wvalid_i),
        .inport1_wdata_i(inport1_wdata_i), .inport1_wstrb_i(inport1_wstrb_i),
        .inport1_wlast_i(inport1_wlast_i), .inport1_bready_i(inport1_bready_i),
        .inport1_arvalid_i(inport1_arvalid_i), .inport1_araddr_i(inport1_araddr_i),
        .inport1_arid_i(inport1_arid_i), .inport1_arlen_i(inport1_arlen_i),
        .inport1_arburst_i(inport1_arburst_i), .inport1_rready_i(inport1_rready_i),
        .inport1_awready_o(r0_inport1_awready_o), .inport1_wready_o(r0_inport1_wready_o),
        .inport1_arready_o(r0_inport1_arready_o), .inport1_bvalid_o(r0_inport1_bvalid_o),
        .inport1_bresp_o(r0_inport1_bresp_o), .inport1_bid_o(r0_inport1_bid_o),
        .inport1_rvalid_o(r0_inport1_rvalid_o), .inport1_rdata_o(r0_inport1_rdata_o),
        .inport1_rresp_o(r0_inport1_rresp_o), .inport1_rid_o(r0_inport1_rid_o),
        .inport1_rlast_o(r0_inport1_rlast_o),
        .outport_awvalid_o(r0_outport_awvalid_o), .outport_awaddr_o(r0_outport_awaddr_o),
        .outport_awid_o(r0_outport_awid_o), .outport_awlen_o(r0_outport_awlen_o),
        .outport_awburst_o(r0_outport_awburst_o), .outport_wvalid_o(r0_outport_wvalid_o),
        .outport_wdata_o(r0_outport_wdata_o), .outport_wstrb_o(r0_outport_wstrb_o),
        .outport_wlast_o(r0_outport_wlast_o), .outport_bready_o(r0_outport_bready_o),
        .outport_arvalid_o(r0_outport_arvalid_o), .outport_araddr_o(r0_outport_araddr_o),
        .outport_arid_o(r0_outport_arid_o), .outport_arlen_o(r0_outport_arlen_o),
        .outport_arburst_o(r0_outport_arburst_o), .outport_rready_o(r0_outport_rready_o),
        .outport_awready_i(outport_awready_i), .outport_wready_i(outport_wready_i),
        .outport_arready_i(outport_arready_i), .outport_bvalid_i(outport_bvalid_i),
        .outport_bresp_i(outport_bresp_i), .outport_bid_i(outport_bid_i),
        .outport_rvalid_i(outport_rvalid_i), .outport_rdata_i(outport_rdata_i),
        .outport_rresp_i(outport_rresp_i), .outport_rid_i(outport_rid_i),
        .outport_rlast_i(outport_rlast_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inport0_awvalid_i = 1'b0; inport0_awaddr_i = 32'h0; inport0_awid_i = 4'h0;
        inport0_awlen_i = 8'h0; inport0_awburst_i = 2'b00; inport0_wvalid_i = 1'b0;
        inport0_wdata_i = 32'h0; inport0_wstrb_i = 4'h0; inport0_wlast_i = 1'b0;
        inport0_bready_i = 1'b0; inport0_arvalid_i = 1'b0; inport0_araddr_i = 32'h0;
        inport0_arid_i = 4'h0; inport0_arlen_i = 8'h0; inport0_arburst_i = 2'b00;
        inport0_rready_i = 1'b0;
        inport1_awvalid_i = 1'b0; inport1_awaddr_i = 32'h0; inport1_awid_i = 4'h0;
        inport1_awlen_i = 8'h0; inport1_awburst_i = 2'b00; inport1_wvalid_i = 1'b0;
        inport1_wdata_i = 32'h0; inport1_wstrb_i = 4'h0; inport1_wlast_i = 1'b0;
        inport1_bready_i = 1'b0; inport1_arvalid_i = 1'b0; inport1_araddr_i = 32'h0;
        inport1_arid_i = 4'h0; inport1_arlen_i = 8'h0; inport1_arburst_i = 2'b00;
        inport1_rready_i = 1'b0;
        outport_awready_i = 1'b0; outport_wready_i = 1'b0; outport_arready_i = 1'b0;
        outport_bvalid_i = 1'b0; outport_bresp_i = 2'b00; outport_bid_i = 4'h0;
        outport_rvalid_i = 1'b0; outport_rdata_i = 32'h0; outport_rresp_i = 2'b00;
        outport_rid_i = 4'h0; outport_rlast_i = 1'b0;
    endtask

    initial begin
        int  beat;
        int  cyc;
        int  stall;
        logic exp_g;

        // ---------------- reset state ----------------
        clear_inputs();
        rst = 1'b1;
        #1;
        chk("reset_vr", 64'(vr_all), 64'd0);
        chk("reset_awaddr", 64'(outport_awaddr_o), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ---------------- single write from inport0, wready toggling -----
        inport0_awvalid_i = 1'b1; inport0_awaddr_i = 32'h100; inport0_awid_i = 4'h2;
        inport0_awlen_i = 8'd3; inport0_awburst_i = 2'b01;
        #1;
        chk("s1_idle_awvalid", 64'(outport_awvalid_o), 64'd0);
        chk("s1_idle_awready0", 64'(inport0_awready_o), 64'd0);
        tick();
        chk("s1_awvalid", 64'(outport_awvalid_o), 64'd1);
        chk("s1_awaddr", 64'(outport_awaddr_o), 64'h100);
        chk("s1_awid", 64'(outport_awid_o), 64'h2);
        chk("s1_awlen", 64'(outport_awlen_o), 64'd3);
        chk("s1_awburst", 64'(outport_awburst_o), 64'd1);
        chk("s1_awready0_low", 64'(inport0_awready_o), 64'd0);
        outport_awready_i = 1'b1;
        #1;
        chk("s1_awready0", 64'(inport0_awready_o), 64'd1);
        chk("s1_awready1", 64'(inport1_awready_o), 64'd0);
        tick();
        inport0_awvalid_i = 1'b0; outport_awready_i = 1'b0;
        beat = 0; cyc = 0;
        while (beat < 4 && cyc < 20) begin
            inport0_wvalid_i = 1'b1; inport0_wdata_i = 32'hA0 + 32'(beat);
            inport0_wstrb_i = 4'hF; inport0_wlast_i = (beat == 3);
            outport_wready_i = (cyc % 2 == 1);
            #1;
            chk("s1_wvalid", 64'(outport_wvalid_o), 64'd1);
            chk("s1_wdata", 64'(outport_wdata_o), 64'(32'hA0 + 32'(beat)));
            chk("s1_wlast", 64'(outport_wlast_o), 64'(beat == 3));
            chk("s1_wready0", 64'(inport0_wready_o), 64'(outport_wready_i));
            chk("s1_wready1", 64'(inport1_wready_o), 64'd0);
            if (outport_wready_i) beat++;
            cyc++;
            tick();
        end
        chk("s1_beats", 64'(beat), 64'd4);
        inport0_wvalid_i = 1'b0; outport_wready_i = 1'b0;
        #1;
        chk("s1_resp_wvalid", 64'(outport_wvalid_o), 64'd0);
        outport_bvalid_i = 1'b1; outport_bid_i = 4'h2; outport_bresp_i = 2'b00;
        inport0_bready_i = 1'b1;
        #1;
        chk("s1_bvalid0", 64'(inport0_bvalid_o), 64'd1);
        chk("s1_bid0", 64'(inport0_bid_o), 64'h2);
        chk("s1_bvalid1", 64'(inport1_bvalid_o), 64'd0);
        chk("s1_bready", 64'(outport_bready_o), 64'd1);
        tick();
        chk("s1_idle_bvalid0", 64'(inport0_bvalid_o), 64'd0);
        chk("s1_idle_bready", 64'(outport_bready_o), 64'd0);

        // ---------------- early W, then concurrent read/write ----------
        clear_inputs();
        tick();
        inport1_wvalid_i = 1'b1; inport1_wdata_i = 32'hB0; inport1_wstrb_i = 4'h3;
        inport1_wlast_i = 1'b1; outport_wready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s2_early_wready1", 64'(inport1_wready_o), 64'd0);
            chk("s2_early_wvalid", 64'(outport_wvalid_o), 64'd0);
            tick();
        end
        inport1_awvalid_i = 1'b1; inport1_awaddr_i = 32'h300; inport1_awid_i = 4'h5;
        inport1_awlen_i = 8'd0; inport1_awburst_i = 2'b01;
        inport0_arvalid_i = 1'b1; inport0_araddr_i = 32'h400; inport0_arid_i = 4'h6;
        inport0_arlen_i = 8'd7; inport0_arburst_i = 2'b01;
        #1;
        chk("s2_idle_wready1", 64'(inport1_wready_o), 64'd0);
        tick();
        chk("s2_awvalid", 64'(outport_awvalid_o), 64'd1);
        chk("s2_awaddr", 64'(outport_awaddr_o), 64'h300);
        chk("s2_arvalid", 64'(outport_arvalid_o), 64'd1);
        chk("s2_araddr", 64'(outport_araddr_o), 64'h400);
        chk("s2_arlen", 64'(outport_arlen_o), 64'd7);
        chk("s2_arid", 64'(outport_arid_o), 64'h6);
        chk("s2_addr_wready1", 64'(inport1_wready_o), 64'd0);
        chk("s2_addr_wvalid", 64'(outport_wvalid_o), 64'd0);
        outport_awready_i = 1'b1; outport_arready_i = 1'b1;
        #1;
        chk("s2_awready1", 64'(inport1_awready_o), 64'd1);
        chk("s2_awready0", 64'(inport0_awready_o), 64'd0);
        chk("s2_arready0", 64'(inport0_arready_o), 64'd1);
        chk("s2_arready1", 64'(inport1_arready_o), 64'd0);
        tick();
        inport1_awvalid_i = 1'b0; inport0_arvalid_i = 1'b0;
        outport_awready_i = 1'b0; outport_arready_i = 1'b0;
        outport_rvalid_i = 1'b1; outport_rdata_i = 32'hC0; outport_rid_i = 4'h6;
        outport_rresp_i = 2'b00; outport_rlast_i = 1'b0; inport0_rready_i = 1'b1;
        #1;
        chk("s2_wvalid", 64'(outport_wvalid_o), 64'd1);
        chk("s2_wdata", 64'(outport_wdata_o), 64'hB0);
        chk("s2_wstrb", 64'(outport_wstrb_o), 64'h3);
        chk("s2_wready1", 64'(inport1_wready_o), 64'd1);
        chk("s2_rvalid0", 64'(inport0_rvalid_o), 64'd1);
        chk("s2_rdata0", 64'(inport0_rdata_o), 64'hC0);
        chk("s2_rid0", 64'(inport0_rid_o), 64'h6);
        chk("s2_rvalid1", 64'(inport1_rvalid_o), 64'd0);
        chk("s2_rready", 64'(outport_rready_o), 64'd1);
        tick();
        inport1_wvalid_i = 1'b0; outport_wready_i = 1'b0;
        outport_bvalid_i = 1'b1; outport_bid_i = 4'h5; outport_bresp_i = 2'b01;
        inport1_bready_i = 1'b1; outport_rdata_i = 32'hC1;
        #1;
        chk("s2_bvalid1", 64'(inport1_bvalid_o), 64'd1);
        chk("s2_bid1", 64'(inport1_bid_o), 64'h5);
        chk("s2_bresp1", 64'(inport1_bresp_o), 64'd1);
        chk("s2_bvalid0", 64'(inport0_bvalid_o), 64'd0);
        chk("s2_bready", 64'(outport_bready_o), 64'd1);
        chk("s2_rdata1", 64'(inport0_rdata_o), 64'hC1);
        tick();
        outport_bvalid_i = 1'b0; inport1_bready_i = 1'b0;
        beat = 2; cyc = 0; stall = 0;
        while (beat < 8 && cyc < 30) begin
            inport0_rready_i = !(beat == 3 && stall < 5);
            outport_rdata_i = 32'hC0 + 32'(beat);
            outport_rlast_i = (beat == 7);
            #1;
            chk("s2_rvalid", 64'(inport0_rvalid_o), 64'd1);
            chk("s2_rdata", 64'(inport0_rdata_o), 64'(32'hC0 + 32'(beat)));
            chk("s2_rlast", 64'(inport0_rlast_o), 64'(beat == 7));
            chk("s2_rready_fwd", 64'(outport_rready_o), 64'(inport0_rready_i));
            chk("s2_rvalid1_idle", 64'(inport1_rvalid_o), 64'd0);
            if (inport0_rready_i) beat++; else stall++;
            cyc++;
            tick();
        end
        chk("s2_rbeats", 64'(beat), 64'd8);
        chk("s2_rstall", 64'(stall), 64'd5);
        chk("s2_rd_idle_rvalid0", 64'(inport0_rvalid_o), 64'd0);
        chk("s2_rd_idle_rready", 64'(outport_rready_o), 64'd0);

        // ---------------- contention: continuous requests on both ports -----
        clear_inputs();
        tick();
        inport0_awvalid_i = 1'b1; inport0_awaddr_i = 32'h200; inport0_awburst_i = 2'b01;
        inport1_awvalid_i = 1'b1; inport1_awaddr_i = 32'h300; inport1_awburst_i = 2'b01;
        inport0_wvalid_i = 1'b1; inport0_wdata_i = 32'hD0; inport0_wstrb_i = 4'hF; inport0_wlast_i = 1'b1;
        inport1_wvalid_i = 1'b1; inport1_wdata_i = 32'hD1; inport1_wstrb_i = 4'hF; inport1_wlast_i = 1'b1;
        inport0_bready_i = 1'b1; inport1_bready_i = 1'b1;
        outport_awready_i = 1'b1; outport_wready_i = 1'b1; outport_bvalid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 1);
            #1;
            chk("s3_idle_awvalid", 64'(outport_awvalid_o), 64'd0);
            tick();
            chk("s3_rr_awaddr", 64'(outport_awaddr_o), exp_g ? 64'h300 : 64'h200);
            chk("s3_rr_awready0", 64'(inport0_awready_o), 64'(!exp_g));
            chk("s3_rr_awready1", 64'(inport1_awready_o), 64'(exp_g));
            chk("s3_fixed_awaddr", 64'(r0_outport_awaddr_o), 64'h200);
            chk("s3_fixed_awready0", 64'(r0_inport0_awready_o), 64'd1);
            tick();
            chk("s3_rr_wdata", 64'(outport_wdata_o), exp_g ? 64'hD1 : 64'hD0);
            chk("s3_fixed_wdata", 64'(r0_outport_wdata_o), 64'hD0);
            tick();
            chk("s3_rr_bvalid0", 64'(inport0_bvalid_o), 64'(!exp_g));
            chk("s3_rr_bvalid1", 64'(inport1_bvalid_o), 64'(exp_g));
            tick();
        end

        // ---------------- reset mid-burst ----------------
        clear_inputs();
        tick();
        inport0_awvalid_i = 1'b1; inport0_awaddr_i = 32'h600; inport0_awlen_i = 8'd3;
        inport0_arvalid_i = 1'b1; inport0_araddr_i = 32'h800;
        tick();
        outport_awready_i = 1'b1;
        tick();
        inport0_awvalid_i = 1'b0; outport_awready_i = 1'b0;
        inport0_wvalid_i = 1'b1; inport0_wdata_i = 32'hE0; inport0_wlast_i = 1'b0;
        outport_wready_i = 1'b1;
        tick();
        inport0_wdata_i = 32'hE1;
        outport_rvalid_i = 1'b1; outport_bvalid_i = 1'b1;
        inport0_rready_i = 1'b1; inport0_bready_i = 1'b1;
        #1;
        chk("s4_pre_wvalid", 64'(outport_wvalid_o), 64'd1);
        chk("s4_pre_arvalid", 64'(outport_arvalid_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("s4_rst_async_vr", 64'(vr_all), 64'd0);
        tick();
        chk("s4_rst_held_vr", 64'(vr_all), 64'd0);
        clear_inputs();
        rst = 1'b0;
        tick();
        // last-grant must be back at 1: inport0 wins this read contention
        inport0_arvalid_i = 1'b1; inport0_araddr_i = 32'h800;
        inport1_arvalid_i = 1'b1; inport1_araddr_i = 32'h900;
        tick();
        chk("s4_rd_contend_addr", 64'(outport_araddr_o), 64'h800);
        outport_arready_i = 1'b1;
        #1;
        chk("s4_rd_arready0", 64'(inport0_arready_o), 64'd1);
        tick();
        inport0_arvalid_i = 1'b0; inport1_arvalid_i = 1'b0; outport_arready_i = 1'b0;
        outport_rvalid_i = 1'b1; outport_rlast_i = 1'b1; inport0_rready_i = 1'b1;
        tick();
        clear_inputs();
        tick();
        // fresh inport1 write after reset
        inport1_awvalid_i = 1'b1; inport1_awaddr_i = 32'h500; inport1_awid_i = 4'h7;
        inport1_awlen_i = 8'd1; inport1_awburst_i = 2'b01;
        tick();
        chk("s4_awaddr", 64'(outport_awaddr_o), 64'h500);
        chk("s4_awid", 64'(outport_awid_o), 64'h7);
        outport_awready_i = 1'b1;
        #1;
        chk("s4_awready1", 64'(inport1_awready_o), 64'd1);
        tick();
        inport1_awvalid_i = 1'b0; outport_awready_i = 1'b0;
        inport1_wvalid_i = 1'b1; inport1_wdata_i = 32'hF0; inport1_wstrb_i = 4'hF;
        inport1_wlast_i = 1'b0; outport_wready_i = 1'b1;
        #1;
        chk("s4_wdata0", 64'(outport_wdata_o), 64'hF0);
        chk("s4_wready1", 64'(inport1_wready_o), 64'd1);
        tick();
        inport1_wdata_i = 32'hF1; inport1_wlast_i = 1'b1;
        #1;
        chk("s4_wdata1", 64'(outport_wdata_o), 64'hF1);
        chk("s4_wlast", 64'(outport_wlast_o), 64'd1);
        tick();
        inport1_wvalid_i = 1'b0; outport_wready_i = 1'b0;
        outport_bvalid_i = 1'b1; outport_bid_i = 4'h7; inport1_bready_i = 1'b1;
        #1;
        chk("s4_bvalid1", 64'(inport1_bvalid_o), 64'd1);
        chk("s4_bid1", 64'(inport1_bid_o), 64'h7);
        chk("s4_bvalid0", 64'(inport0_bvalid_o), 64'd0);
        tick();
        clear_inputs();
        #1;
        chk("s4_idle_bvalid1", 64'(inport1_bvalid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
